// File: rtl/fir_pkg.sv
// Shared definitions for the FIR block scheduler and its wrapper:
// sample width, scheduler state encoding and reserved PIO codes.
package fir_pkg;

   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_FLUSH,
      ST_DRAIN
   } sched_state_t;

   // Reserved control words on the PIO path; the wrapper must never pass these as samples.
   localparam logic [SAMPLE_W-1:0] PIO_RSVD_0 = 16'h8000;
   localparam logic [SAMPLE_W-1:0] PIO_RSVD_1 = 16'h8001;

endpackage

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above rr_ptr,
// wrapping modulo NUM_REQ. The pointer itself lives in the scheduler.
module fir_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_req
);

   int idx;

   // NOTE: every signal written here gets a default before the loop; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!any_req && req[idx]) begin
            any_req    = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fir_block_scheduler.sv
// Shares one FIR between NUM_REQ requesters a whole block at a time, flushes
// the filter history with TAPS zeros and tags the block's outputs with the owner.
module fir_block_scheduler
   import fir_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int SIGNAL_SIZE_LOG = 7,
   parameter int TAPS            = 4,
   parameter int ID_W            = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [SAMPLE_W*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         fir_valid_in,
   output logic [SAMPLE_W-1:0]          fir_data_in,
   input  logic                         fir_valid_out,
   input  logic [SAMPLE_W-1:0]          fir_data_out,
   output logic                         out_valid,
   output logic [SAMPLE_W-1:0]          out_data,
   output logic [ID_W-1:0]              out_id,
   output logic                         out_last,
   output logic                         busy,
   output logic                         err_spurious
);

   localparam int BLOCK_LEN = 1 << SIGNAL_SIZE_LOG;
   localparam int TOTAL_OUT = BLOCK_LEN + TAPS;
   localparam int IN_W      = SIGNAL_SIZE_LOG + 1;
   localparam int OUT_W     = $clog2(TOTAL_OUT) + 1;
   localparam int FL_W      = $clog2(TAPS) + 1;

   localparam logic [IN_W-1:0]  IN_LAST      = IN_W'(BLOCK_LEN - 1);
   localparam logic [OUT_W-1:0] OUT_FWD_LAST = OUT_W'(BLOCK_LEN - 1);
   localparam logic [OUT_W-1:0] OUT_FULL     = OUT_W'(TOTAL_OUT);
   localparam logic [FL_W-1:0]  FL_LAST      = FL_W'(TAPS - 1);
   localparam logic [ID_W-1:0]  ID_MAX       = ID_W'(NUM_REQ - 1);

   sched_state_t         state;
   logic [ID_W-1:0]      grant_id;
   logic [ID_W-1:0]      rr_ptr;
   logic [IN_W-1:0]      in_cnt;
   logic [OUT_W-1:0]     out_cnt;
   logic [FL_W-1:0]      flush_cnt;

   logic [NUM_REQ-1:0]   arb_grant;
   logic [ID_W-1:0]      arb_idx;
   logic                 arb_any;
   logic                 accept;
   logic [SAMPLE_W-1:0]  sel_data;

   fir_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_req   (arb_any)
   );

   // req_ready is one-hot on the owner during STREAM and zero otherwise,
   // so it doubles as the data select.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) sel_data = req_data[i*SAMPLE_W +: SAMPLE_W];
      end
   end

   assign accept = |(req_valid & req_ready);

   // NOTE: all state here is updated with non-blocking assignments so every
   // branch reads the pre-edge values of the counters it compares against.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         grant_id     <= '0;
         rr_ptr       <= '0;
         in_cnt       <= '0;
         out_cnt      <= '0;
         flush_cnt    <= '0;
         req_ready    <= '0;
         fir_valid_in <= 1'b0;
         fir_data_in  <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_id       <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         fir_valid_in <= 1'b0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  state     <= ST_STREAM;
                  grant_id  <= arb_idx;
                  req_ready <= arb_grant;
                  in_cnt    <= '0;
                  out_cnt   <= '0;
                  flush_cnt <= '0;
                  busy      <= 1'b1;
               end
            end
            ST_STREAM: begin
               if (accept) begin
                  fir_valid_in <= 1'b1;
                  fir_data_in  <= sel_data;
                  in_cnt       <= in_cnt + 1'b1;
                  if (in_cnt == IN_LAST) begin
                     req_ready <= '0;
                     state     <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               fir_valid_in <= 1'b1;
               fir_data_in  <= '0;
               flush_cnt    <= flush_cnt + 1'b1;
               if (flush_cnt == FL_LAST) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (out_cnt == OUT_FULL) begin
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
                  rr_ptr <= (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Outputs past the flush tail, or with no block open, are protocol errors.
         if (fir_valid_out) begin
            if (state == ST_IDLE || out_cnt == OUT_FULL) begin
               err_spurious <= 1'b1;
            end else begin
               out_cnt <= out_cnt + 1'b1;
               if (out_cnt <= OUT_FWD_LAST) begin
                  out_valid <= 1'b1;
                  out_data  <= fir_data_out;
                  out_id    <= grant_id;
                  out_last  <= (out_cnt == OUT_FWD_LAST);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_block_scheduler.sv
// Scoreboard bench for fir_block_scheduler: a 4-tap FIR model (7,6,7,2) sits
// behind the scheduler and a monitor checks every tagged output against a queue.
module tb_fir_block_scheduler;

   localparam int NUM_REQ = 2;
   localparam int SSL     = 7;
   localparam int TAPS    = 4;
   localparam int ID_W    = 3;
   localparam int BLOCK   = 1 << SSL;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_REQ-1:0]      req_valid;
   logic [16*NUM_REQ-1:0]   req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    fir_valid_in;
   logic [15:0]             fir_data_in;
   logic                    fir_valid_out;
   logic [15:0]             fir_data_out;
   logic                    out_valid;
   logic [15:0]             out_data;
   logic [ID_W-1:0]         out_id;
   logic                    out_last;
   logic                    busy;
   logic                    err_spurious;

   logic                    fir_v_model;
   logic [15:0]             d1, d2, d3;
   logic                    inj_v;

   typedef struct {
      logic [15:0] data;
      int          id;
      bit          last;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fir_block_scheduler #(
      .NUM_REQ         (NUM_REQ),
      .SIGNAL_SIZE_LOG (SSL),
      .TAPS            (TAPS),
      .ID_W            (ID_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fir_valid_in  (fir_valid_in),
      .fir_data_in   (fir_data_in),
      .fir_valid_out (fir_valid_out),
      .fir_data_out  (fir_data_out),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_id        (out_id),
      .out_last      (out_last),
      .busy          (busy),
      .err_spurious  (err_spurious)
   );

   // FIR stand-in: one-cycle latency, coefficients 7,6,7,2, shares rst.
   always @(posedge clk) begin
      if (rst) begin
         fir_v_model  <= 1'b0;
         fir_data_out <= '0;
         d1 <= '0; d2 <= '0; d3 <= '0;
      end else begin
         fir_v_model <= fir_valid_in;
         if (fir_valid_in) begin
            fir_data_out <= 16'(7*32'(fir_data_in) + 6*32'(d1) + 7*32'(d2) + 2*32'(d3));
            d1 <= fir_data_in;
            d2 <= d1;
            d3 <= d2;
         end
      end
   end

   assign fir_valid_out = fir_v_model | inj_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Constant input c into a cleared filter: running coefficient sums 7,13,20,22.
   function automatic logic [15:0] exp_sample(input logic [15:0] c, input int k);
      int s;
      s = (k == 0) ? 7 : (k == 1) ? 13 : (k == 2) ? 20 : 22;
      return 16'(32'(c) * s);
   endfunction

   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got data %0h id %0d with nothing expected at %0t",
                     out_data, out_id, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_id",   32'(out_id),   32'(e.id));
            check("out_last", 32'(out_last), 32'(e.last));
         end
      end
   end

   task automatic check_reset_state();
      check("rst_req_ready",    32'(req_ready),    0);
      check("rst_fir_valid_in", 32'(fir_valid_in), 0);
      check("rst_fir_data_in",  32'(fir_data_in),  0);
      check("rst_out_valid",    32'(out_valid),    0);
      check("rst_out_data",     32'(out_data),     0);
      check("rst_out_id",       32'(out_id),       0);
      check("rst_out_last",     32'(out_last),     0);
      check("rst_busy",         32'(busy),         0);
      check("rst_err",          32'(err_spurious), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state();
      sb.delete();
      rst = 1'b0;
   endtask

   // Drive one requester until max_acc samples are accepted, pushing the
   // expected block when the grant is first observed.
   task automatic send_block(input int r, input logic [15:0] c, input bit bubble, input int max_acc);
      int                 acc = 0;
      int                 cyc = 0;
      int                 bad_ready = 0;
      int                 bad_fin = 0;
      bit                 granted = 1'b0;
      bit                 prev_acc = 1'b0;
      bit                 ph = 1'b1;
      logic [NUM_REQ-1:0] exp_rdy;
      exp_t               e;
      exp_rdy    = '0;
      exp_rdy[r] = 1'b1;
      req_data[r*16 +: 16] = c;
      while (acc < max_acc && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (granted) begin
            if (fir_valid_in !== prev_acc || (prev_acc && fir_data_in !== c)) bad_fin++;
            if (req_ready !== exp_rdy) bad_ready++;
         end
         req_valid[r] = bubble ? ph : 1'b1;
         ph = ~ph;
         prev_acc = 1'b0;
         if (req_valid[r] && req_ready[r]) begin
            if (!granted) begin
               granted = 1'b1;
               grant_log.push_back(r);
               for (int k = 0; k < BLOCK; k++) begin
                  e.data = exp_sample(c, k);
                  e.id   = r;
                  e.last = (k == BLOCK - 1);
                  sb.push_back(e);
               end
            end
            acc++;
            prev_acc = 1'b1;
         end
      end
      @(negedge clk);
      if (fir_valid_in !== 1'b1 || fir_data_in !== c) bad_fin++;
      if (acc == BLOCK) check("ready_drop", 32'(req_ready), 0);
      req_valid[r] = 1'b0;
      check("accepts", acc, max_acc);
      check("ready_excl", bad_ready, 0);
      check("fir_in_match", bad_fin, 0);
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("idle_busy", 32'(busy), 0);
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      inj_v     = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state();

      // Contention from reset release: grant order 0,1,0.
      rst = 1'b0;
      grant_log.delete();
      fork
         begin
            send_block(0, 16'h0002, 1'b0, BLOCK);
            send_block(0, 16'h0003, 1'b0, BLOCK);
         end
         send_block(1, 16'h0004, 1'b0, BLOCK);
      join
      wait_idle();
      check("grant_cnt", grant_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         int g;
         g = (i < grant_log.size()) ? grant_log[i] : 7;
         check("grant_order", g, (i == 1) ? 1 : 0);
      end

      // Single requester, unit samples.
      send_block(0, 16'h0001, 1'b0, BLOCK);
      wait_idle();

      // Requester 1 with bubbles every other cycle.
      send_block(1, 16'h0005, 1'b1, BLOCK);
      wait_idle();

      // Flush isolation: a full-scale block followed by an all-zero block.
      send_block(0, 16'h7FFF, 1'b0, BLOCK);
      send_block(1, 16'h0000, 1'b0, BLOCK);
      wait_idle();

      // Reset in the middle of requester 1's block while rr_ptr points at 1.
      send_block(0, 16'h0006, 1'b0, BLOCK);
      wait_idle();
      send_block(1, 16'h0009, 1'b0, 10);
      do_reset();
      grant_log.delete();
      fork
         send_block(0, 16'h000A, 1'b0, BLOCK);
         send_block(1, 16'h000B, 1'b0, BLOCK);
      join
      wait_idle();
      check("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : 7, 0);

      // FIR output with no block open.
      @(negedge clk);
      inj_v = 1'b1;
      @(negedge clk);
      inj_v = 1'b0;
      check("err_set", 32'(err_spurious), 1);
      check("err_no_out", 32'(out_valid), 0);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(err_spurious), 1);
      check("err_idle", 32'(busy), 0);
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
      $fatal(1);
   end

endmodule
